// File: rtl/stage_pipe_queue.sv
// Elastic buffer between two pipeline stages: registered head word, one-cycle
// latency, optional full-queue pass-through when the consumer drains the head.
module stage_pipe_queue #(
   parameter int DATA_WIDTH   = 256,
   parameter int DEPTH        = 2,
   parameter bit BYPASS_READY = 1'b1,
   parameter int COUNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   upstream_valid,
   input  logic [DATA_WIDTH-1:0]  upstream_data,
   output logic                   upstream_allow_in,
   output logic                   downstream_valid,
   output logic [DATA_WIDTH-1:0]  downstream_data,
   input  logic                   downstream_allow_in,
   input  logic                   flush,
   output logic [COUNT_WIDTH-1:0] occupancy,
   output logic                   overflow_error
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(DEPTH);
   localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [6:0]             WD_LIMIT = 7'd64;

   typedef enum logic {EMPTY, HOLDING} state_e;

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [PTR_W-1:0]       wptr_q, wptr_d;
   logic [PTR_W-1:0]       rptr_q, rptr_d;
   logic [6:0]             wd_cnt_q, wd_cnt_d;
   logic                   ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

   logic full, push, pop, stall;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign full              = (count_q == FULL_CNT);
   assign downstream_valid  = (state_q == HOLDING);
   assign downstream_data   = mem_q[rptr_q];
   assign occupancy         = count_q;
   assign overflow_error    = ovf_q;
   // With BYPASS_READY=0 the second term folds away, leaving a register-only ready.
   assign upstream_allow_in = !full ||
                              (BYPASS_READY && downstream_allow_in && (state_q == HOLDING));

   assign push  = upstream_valid && upstream_allow_in && !flush;
   assign pop   = downstream_valid && downstream_allow_in && !flush;
   assign stall = upstream_valid && !upstream_allow_in && full && !BYPASS_READY;

   always_comb begin
      count_d  = count_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      wd_cnt_d = wd_cnt_q;
      ovf_d    = ovf_q;

      if (flush) begin
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
      end else begin
         if (push) wptr_d = next_ptr(wptr_q);
         if (pop)  rptr_d = next_ptr(rptr_q);
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end

      state_d = (count_d != '0) ? HOLDING : EMPTY;

      // Watchdog saturates at its limit; the sticky flag fires on the next stalled cycle.
      if (stall) begin
         if (wd_cnt_q == WD_LIMIT) ovf_d = 1'b1;
         else                      wd_cnt_d = wd_cnt_q + 1'b1;
      end else begin
         wd_cnt_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= EMPTY;
         count_q  <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         wd_cnt_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         wd_cnt_q <= wd_cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wptr_q] <= upstream_data;
      end
   end

endmodule
